demux_barrido: RTL and testbench
================================

// Module: demux_barrido
// PURPOSE
// - Scanning reader for the shared 4:1 sensor/status mux of the fire-fighting machine controller.
// - Drives the mux select lines in round-robin order (channel 0,1,2,3,0,...).
// - Waits a programmable settle time on each channel, then captures the muxed word
//   into that channel's dedicated output register and flags it valid.
// - Sits between the mux output and the control FSM, which reads Salida1..4 as static registers.
// PARAMETERS
// - N        10  MSB index of data words; all data buses are [N:0] (N+1 bits), matching the mux.
// - SETTLE   4   cycles select is held before capture; legal range 1..255.
// PORTS
// - clk             in   1      system clock; all logic on rising edge.
// - reset           in   1      synchronous, active-high reset.
// - enable          in   1      level; high = keep scanning, low = stop at next channel boundary.
// - dato_mux        in   N+1    muxed word returned for the current seleccion.
// - seleccion       out  2      select driven to the mux (00=ch0 .. 11=ch3), registered.
// - Salida1..Salida4 out N+1    captured word for ch0..ch3, registered.
// - valido          out  4      bit k = Salida(k+1) captured since current scan started.
// - ciclo_completo  out  1      one-cycle pulse after ch3 is captured.
// - ocupado         out  1      high while in ESPERA.
// BEHAVIOUR
// - Reset (sync): state=INACTIVO, seleccion=00, cnt=0, Salida1..4=0, valido=0000,
//   ciclo_completo=0, ocupado=0. Reset overrides everything, including mid-scan; no capture that cycle.
// - States: INACTIVO, ESPERA. ocupado = (state==ESPERA).
// - INACTIVO: seleccion=00, cnt=0. If enable=1 at an edge: go ESPERA, clear valido to 0000.
// - ESPERA: cnt increments each cycle from 0.
// - ESPERA, edge where cnt==SETTLE-1 (capture edge):
//   - Salida[seleccion] <= dato_mux; valido[seleccion] <= 1; cnt <= 0.
//   - If seleccion==11: ciclo_completo <= 1 for exactly the next cycle.
//   - If enable=1: seleccion <= seleccion+1 (wrap 11->00); stay in ESPERA; valido not cleared on wrap.
//   - If enable=0: go INACTIVO, seleccion <= 00; valido and Salida retained.
// - Timing:
//   - Channel k's data is sampled exactly SETTLE cycles after seleccion first shows k.
//   - One full scan = 4*SETTLE cycles.
//   - First capture occurs SETTLE+1 edges after enable rises in INACTIVO.
// - enable falling mid-channel is ignored until that channel's capture edge; the capture still happens.
// - SETTLE=1: capture every cycle; seleccion advances every cycle.
// - cnt width = 8 bits; it never exceeds SETTLE-1.
// - Salida registers not being captured hold their value.
// - Only one Salida register changes per edge.
// STRUCTURE
// - Shared package/include:
//   - channel codes CH0..CH3 = 2'b00..2'b11, shared with the mux select decode.
//   - state encodings INACTIVO=1'b0, ESPERA=1'b1.
// - Sub-module contador_asentamiento: loadable settle counter with clear and terminal-count output
//   (tc = cnt==SETTLE-1).
// - Top level holds the FSM, the select register, the capture decode, and the four Salida registers.
// TESTING
// - Pair with the 4:1 mux model, channel inputs 0x101/0x202/0x303/0x3FF, N=10, SETTLE=4.
// - Reset then enable=1: seleccion shows 00,01,10,11 for 4 cycles each.
//   -> Salida1..4 = 0x101/0x202/0x303/0x3FF; valido 0001->0011->0111->1111;
//   ciclo_completo high 1 cycle, 16 cycles after the first ESPERA cycle.
// - Change the ch2 input to 0x055 mid-scan while seleccion=01.
//   -> Salida3 = 0x055 after the next capture; other Salida unchanged.
// - Drop enable 1 cycle after seleccion becomes 10.
//   -> ch2 still captured at its capture edge; then INACTIVO, seleccion=00, valido=0111 held, ocupado=0.
// - Re-raise enable from INACTIVO.
//   -> valido clears to 0000 on entry; scan restarts at ch0.
// - Assert reset during ESPERA with cnt=2.
//   -> next cycle all outputs zero, no capture, state INACTIVO.
// - SETTLE=1 build: capture every cycle; ciclo_completo pulses every 4 cycles; valido=1111 after 4 cycles.

Source files
------------

// File: rtl/demux_barrido_pkg.sv
// ============================================================================
// Module   : demux_barrido_pkg
// Brief    : Channel codes, FSM state encodings and select helper shared by
//            the scanning mux reader and the mux select decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

package demux_barrido_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    CH0 = 2'b00,
    CH1 = 2'b01,
    CH2 = 2'b10,
    CH3 = 2'b11
  } canal_e;

  typedef enum logic [0:0] {
    INACTIVO = 1'b0,
    ESPERA   = 1'b1
  } estado_e;

  // Round-robin successor; CH3 wraps to CH0 through the natural 2-bit overflow.
  function automatic canal_e canal_sig(input canal_e c);
    logic [1:0] t;
    t = c + 2'd1;
    return canal_e'(t);
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_barrido_if.sv
// ============================================================================
// Module   : demux_barrido_if
// Brief    : Bus between the scanning reader, the 4:1 mux and the control FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface demux_barrido_if #(
  parameter int N = 10
);

  logic       enable;
  logic [N:0] dato_mux;
  logic [1:0] seleccion;
  logic [N:0] Salida1;
  logic [N:0] Salida2;
  logic [N:0] Salida3;
  logic [N:0] Salida4;
  logic [3:0] valido;
  logic       ciclo_completo;
  logic       ocupado;

  modport slave (
    input  enable,
    input  dato_mux,
    output seleccion,
    output Salida1,
    output Salida2,
    output Salida3,
    output Salida4,
    output valido,
    output ciclo_completo,
    output ocupado
  );

  modport master (
    output enable,
    output dato_mux,
    input  seleccion,
    input  Salida1,
    input  Salida2,
    input  Salida3,
    input  Salida4,
    input  valido,
    input  ciclo_completo,
    input  ocupado
  );

endinterface

`default_nettype wire

// File: rtl/demux_barrido_contador_asentamiento.sv
// ============================================================================
// Module   : contador_asentamiento
// Brief    : Loadable settle counter with clear; tc flags cnt == SETTLE-1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module contador_asentamiento
  import demux_barrido_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             clr,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] load_val,
  input  wire logic             en,
  output logic                  tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(SETTLE - 1));

endmodule

`default_nettype wire

// File: rtl/demux_barrido.sv
// ============================================================================
// Module   : demux_barrido
// Brief    : Round-robin scanning reader for a shared 4:1 sensor mux; holds
//            each channel for SETTLE cycles, then latches it into Salida1..4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_barrido
  import demux_barrido_pkg::*;
#(
  parameter int N      = 10,
  parameter int SETTLE = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  demux_barrido_if.slave bus
);

  estado_e    estado_q, estado_d;
  canal_e     sel_q, sel_d;
  logic [3:0] valido_q, valido_d;
  logic       ciclo_q, ciclo_d;
  logic [N:0] salida_q [4];
  logic [N:0] salida_d [4];
  logic       captura;
  logic       tc;
  logic       ocupado;

  assign ocupado = (estado_q == ESPERA);

  // Counter restarts both while idle and on every capture edge.
  contador_asentamiento #(
    .SETTLE (SETTLE)
  ) u_contador (
    .clk      (clk),
    .reset    (reset),
    .clr      (~ocupado),
    .load     (tc),
    .load_val ('0),
    .en       (ocupado),
    .tc       (tc)
  );

  always_comb begin
    estado_d = estado_q;
    sel_d    = sel_q;
    valido_d = valido_q;
    ciclo_d  = 1'b0;
    captura  = 1'b0;
    case (estado_q)
      INACTIVO: begin
        sel_d = CH0;
        if (bus.enable) begin
          estado_d = ESPERA;
          valido_d = 4'b0000;
        end
      end
      ESPERA: begin
        if (tc) begin
          captura          = 1'b1;
          valido_d[sel_q]  = 1'b1;
          ciclo_d          = (sel_q == CH3);
          if (bus.enable) begin
            sel_d = canal_sig(sel_q);
          end else begin
            estado_d = INACTIVO;
            sel_d    = CH0;
          end
        end
      end
      default: begin
        estado_d = INACTIVO;
        sel_d    = CH0;
      end
    endcase
  end

  // Only the register addressed by the current select may load.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      salida_d[k] = salida_q[k];
      if (captura && (sel_q == canal_e'(k))) begin
        salida_d[k] = bus.dato_mux;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= INACTIVO;
      sel_q    <= CH0;
      valido_q <= 4'b0000;
      ciclo_q  <= 1'b0;
      salida_q <= '{default: '0};
    end else begin
      estado_q <= estado_d;
      sel_q    <= sel_d;
      valido_q <= valido_d;
      ciclo_q  <= ciclo_d;
      salida_q <= salida_d;
    end
  end

  assign bus.seleccion      = sel_q;
  assign bus.valido         = valido_q;
  assign bus.ciclo_completo = ciclo_q;
  assign bus.ocupado        = ocupado;
  assign bus.Salida1        = salida_q[0];
  assign bus.Salida2        = salida_q[1];
  assign bus.Salida3        = salida_q[2];
  assign bus.Salida4        = salida_q[3];

endmodule

`default_nettype wire

// File: tb/tb_demux_barrido.sv
// ============================================================================
// Module   : tb_demux_barrido
// Brief    : Directed bench for demux_barrido with a 4:1 mux model (SETTLE=4
//            and SETTLE=1 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux_barrido;

  logic        clk;
  logic        reset;
  logic [10:0] ch [4];
  int          tests;
  int          fails;

  demux_barrido_if #(.N(10)) bus0 ();
  demux_barrido_if #(.N(10)) bus1 ();

  assign bus0.dato_mux = ch[bus0.seleccion];
  assign bus1.dato_mux = ch[bus1.seleccion];

  demux_barrido #(.N(10), .SETTLE(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  demux_barrido #(.N(10), .SETTLE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus0.enable = 1'b0;
    bus1.enable = 1'b0;
    ch[0] = 11'h101;
    ch[1] = 11'h202;
    ch[2] = 11'h303;
    ch[3] = 11'h3FF;
    tick(3);
    reset = 1'b0;
    tick(1);

    chk("rst_sel",    bus0.seleccion,      0);
    chk("rst_valido", bus0.valido,         0);
    chk("rst_ocup",   bus0.ocupado,        0);
    chk("rst_ciclo",  bus0.ciclo_completo, 0);
    chk("rst_s1",     bus0.Salida1,        0);
    chk("rst_s4",     bus0.Salida4,        0);

    // First full scan
    bus0.enable = 1'b1;
    tick(1);
    chk("a_ocup",   bus0.ocupado,   1);
    chk("a_sel0",   bus0.seleccion, 0);
    chk("a_val0",   bus0.valido,    0);
    tick(3);
    chk("a_sel0_hold", bus0.seleccion, 0);
    chk("a_s1_pre",    bus0.Salida1,   0);
    tick(1);
    chk("a_sel1",   bus0.seleccion, 1);
    chk("a_val1",   bus0.valido,    4'b0001);
    chk("a_s1",     bus0.Salida1,   11'h101);
    tick(4);
    chk("a_sel2",   bus0.seleccion, 2);
    chk("a_val2",   bus0.valido,    4'b0011);
    chk("a_s2",     bus0.Salida2,   11'h202);
    tick(4);
    chk("a_sel3",   bus0.seleccion, 3);
    chk("a_val3",   bus0.valido,    4'b0111);
    chk("a_s3",     bus0.Salida3,   11'h303);
    tick(3);
    chk("a_ciclo_pre", bus0.ciclo_completo, 0);
    tick(1);
    chk("a_ciclo",  bus0.ciclo_completo, 1);
    chk("a_val4",   bus0.valido,         4'b1111);
    chk("a_s4",     bus0.Salida4,        11'h3FF);
    chk("a_wrap",   bus0.seleccion,      0);
    tick(1);
    chk("a_ciclo_off", bus0.ciclo_completo, 0);
    chk("a_val_keep",  bus0.valido,         4'b1111);

    // Second scan: change ch2 while seleccion=01
    tick(3);
    chk("b_sel1", bus0.seleccion, 1);
    ch[2] = 11'h055;
    tick(4);
    chk("b_sel2",    bus0.seleccion, 2);
    chk("b_s3_hold", bus0.Salida3,   11'h303);
    tick(4);
    chk("b_s3_new",  bus0.Salida3,   11'h055);
    chk("b_s1_keep", bus0.Salida1,   11'h101);
    chk("b_s2_keep", bus0.Salida2,   11'h202);
    chk("b_s4_keep", bus0.Salida4,   11'h3FF);
    chk("b_sel3",    bus0.seleccion, 3);
    bus0.enable = 1'b0;
    tick(3);
    chk("b_ocup_mid", bus0.ocupado, 1);
    tick(1);
    chk("b_ocup_off", bus0.ocupado,        0);
    chk("b_sel_rst",  bus0.seleccion,      0);
    chk("b_ciclo",    bus0.ciclo_completo, 1);
    tick(1);
    chk("b_ciclo_off", bus0.ciclo_completo, 0);
    chk("b_val_held",  bus0.valido,         4'b1111);

    // Restart, then stop one cycle after seleccion becomes 10
    bus0.enable = 1'b1;
    tick(1);
    chk("c_val_clr", bus0.valido,    0);
    chk("c_ocup",    bus0.ocupado,   1);
    chk("c_sel0",    bus0.seleccion, 0);
    tick(4);
    chk("c_val1", bus0.valido, 4'b0001);
    tick(4);
    chk("c_sel2", bus0.seleccion, 2);
    tick(1);
    bus0.enable = 1'b0;
    tick(2);
    chk("c_ocup_mid", bus0.ocupado, 1);
    tick(1);
    chk("c_ocup_off", bus0.ocupado,   0);
    chk("c_sel_rst",  bus0.seleccion, 0);
    chk("c_val",      bus0.valido,    4'b0111);
    chk("c_s3",       bus0.Salida3,   11'h055);
    tick(2);
    chk("c_val_held", bus0.valido,    4'b0111);
    chk("c_sel_idle", bus0.seleccion, 0);

    // Reset during ESPERA with cnt=2
    bus0.enable = 1'b1;
    tick(3);
    chk("d_ocup", bus0.ocupado, 1);
    reset = 1'b1;
    bus0.enable = 1'b0;
    tick(1);
    chk("d_ocup",   bus0.ocupado,   0);
    chk("d_sel",    bus0.seleccion, 0);
    chk("d_valido", bus0.valido,    0);
    chk("d_s1",     bus0.Salida1,   0);
    chk("d_s2",     bus0.Salida2,   0);
    chk("d_s3",     bus0.Salida3,   0);
    chk("d_s4",     bus0.Salida4,   0);
    reset = 1'b0;
    tick(1);

    // SETTLE=1 instance
    bus1.enable = 1'b1;
    tick(1);
    chk("e_ocup", bus1.ocupado,   1);
    chk("e_sel0", bus1.seleccion, 0);
    tick(1);
    chk("e_sel1", bus1.seleccion, 1);
    chk("e_val1", bus1.valido,    4'b0001);
    tick(3);
    chk("e_ciclo",  bus1.ciclo_completo, 1);
    chk("e_val4",   bus1.valido,         4'b1111);
    chk("e_s4",     bus1.Salida4,        11'h3FF);
    chk("e_s3",     bus1.Salida3,        11'h055);
    tick(1);
    chk("e_ciclo_off", bus1.ciclo_completo, 0);
    tick(3);
    chk("e_ciclo2", bus1.ciclo_completo, 1);
    bus1.enable = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
